// File: rtl/ysyx_210184_mac_pkg.sv
// Shared definitions for the memory access controller: bus width, FSM states,
// funct3 load/store size codes and small size/alignment helpers.
package ysyx_210184_mac_pkg;

    localparam int REG_BUS = 64;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } mac_state_e;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_D  = 3'b011;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;
    localparam logic [2:0] LS_WU = 3'b110;

    // funct3[1:0] encodes log2 of the access size for both signed and unsigned forms.
    function automatic logic [7:0] size_mask(input logic [2:0] bytes);
        case (bytes[1:0])
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] bytes, input logic [2:0] offset);
        case (bytes[1:0])
            2'b00:   return 1'b0;
            2'b01:   return offset[0];
            2'b10:   return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_210184_mac_if.sv
// Memory request/response bus between the access controller (master) and memory (slave).
interface ysyx_210184_mac_if;
    import ysyx_210184_mac_pkg::*;

    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [REG_BUS-1:0] mem_req_addr;
    logic               mem_req_wen;
    logic [REG_BUS-1:0] mem_req_wdata;
    logic [7:0]         mem_req_wstrb;
    logic               mem_rsp_valid;
    logic [REG_BUS-1:0] mem_rsp_data;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

endinterface

// File: rtl/ysyx_210184_load_ext.sv
// Picks the addressed lane out of an aligned 64-bit read word and sign- or
// zero-extends it according to the load funct3.
module ysyx_210184_load_ext
    import ysyx_210184_mac_pkg::*;
(
    input  logic [REG_BUS-1:0] rdata_i,
    input  logic [2:0]         offset_i,
    input  logic [2:0]         size_i,
    output logic [REG_BUS-1:0] data_o
);

    logic [REG_BUS-1:0] lane;

    assign lane = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        data_o = lane;
        case (size_i)
            LS_B:    data_o = {{56{lane[7]}},  lane[7:0]};
            LS_H:    data_o = {{48{lane[15]}}, lane[15:0]};
            LS_W:    data_o = {{32{lane[31]}}, lane[31:0]};
            LS_BU:   data_o = {56'd0, lane[7:0]};
            LS_HU:   data_o = {48'd0, lane[15:0]};
            LS_WU:   data_o = {32'd0, lane[31:0]};
            LS_D:    data_o = lane;
            default: data_o = lane;
        endcase
    end

endmodule

// File: rtl/ysyx_210184_mac.sv
// Memory access controller for the MEM stage: latches a load/store, runs one bus
// transaction, formats the load result and stalls the pipeline until done.
module ysyx_210184_mac
    import ysyx_210184_mac_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_ena_i,
    input  logic               store_ena_i,
    input  logic [2:0]         load_store_bytes_i,
    input  logic [REG_BUS-1:0] addr_i,
    input  logic [REG_BUS-1:0] rs2_data_i,
    input  logic               inst_valid_i,
    output logic               MAC_ready,
    output logic [REG_BUS-1:0] MAC_data,
    output logic               misalign_o,
    ysyx_210184_mac_if.master  mem
);

    mac_state_e         state_q, state_d;
    logic [REG_BUS-1:0] addr_q, addr_d;
    logic [REG_BUS-1:0] wdata_q, wdata_d;
    logic [REG_BUS-1:0] data_q, data_d;
    logic [2:0]         bytes_q, bytes_d;
    logic [7:0]         wstrb_q, wstrb_d;
    logic               wen_q, wen_d;
    logic               misalign_q, misalign_d;

    logic               access;
    logic               misaligned;
    logic [REG_BUS-1:0] load_data;

    assign access     = inst_valid_i & (load_ena_i | store_ena_i);
    assign misaligned = is_misaligned(load_store_bytes_i, addr_i[2:0]);

    ysyx_210184_load_ext u_load_ext (
        .rdata_i  (mem.mem_rsp_data),
        .offset_i (addr_q[2:0]),
        .size_i   (bytes_q),
        .data_o   (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            bytes_q    <= '0;
            wstrb_q    <= '0;
            wen_q      <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            bytes_q    <= bytes_d;
            wstrb_q    <= wstrb_d;
            wen_q      <= wen_d;
            misalign_q <= misalign_d;
        end
    end

    // A simultaneous load and store request is resolved as a load (wen = 0).
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        bytes_d    = bytes_q;
        wstrb_d    = wstrb_q;
        wen_d      = wen_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    addr_d  = addr_i;
                    bytes_d = load_store_bytes_i;
                    wen_d   = ~load_ena_i;
                    wdata_d = rs2_data_i << {addr_i[2:0], 3'b000};
                    wstrb_d = size_mask(load_store_bytes_i) << addr_i[2:0];
                    if (misaligned) begin
                        state_d    = ST_DONE;
                        misalign_d = 1'b1;
                        data_d     = '0;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem.mem_req_ready) begin
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (mem.mem_rsp_valid) begin
                    data_d  = wen_q ? '0 : load_data;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        MAC_ready         = 1'b0;
        mem.mem_req_valid = 1'b0;
        case (state_q)
            ST_IDLE: MAC_ready         = ~access;
            ST_REQ:  mem.mem_req_valid = 1'b1;
            ST_DONE: MAC_ready         = 1'b1;
            default: MAC_ready         = 1'b0;
        endcase
        mem.mem_req_addr  = {addr_q[REG_BUS-1:3], 3'b000};
        mem.mem_req_wen   = wen_q;
        mem.mem_req_wdata = wdata_q;
        mem.mem_req_wstrb = wstrb_q;
        MAC_data          = data_q;
        misalign_o        = misalign_q;
    end

endmodule

// File: tb/tb_ysyx_210184_mac.sv
// Randomised scoreboard bench for the memory access controller, with a
// behavioural memory slave and a reference model of load/store formatting.
module tb_ysyx_210184_mac;

    logic        clk;
    logic        rst;
    logic        load_ena_i;
    logic        store_ena_i;
    logic [2:0]  load_store_bytes_i;
    logic [63:0] addr_i;
    logic [63:0] rs2_data_i;
    logic        inst_valid_i;
    logic        MAC_ready;
    logic [63:0] MAC_data;
    logic        misalign_o;

    ysyx_210184_mac_if mem_bus ();

    ysyx_210184_mac dut (
        .clk                (clk),
        .rst                (rst),
        .load_ena_i         (load_ena_i),
        .store_ena_i        (store_ena_i),
        .load_store_bytes_i (load_store_bytes_i),
        .addr_i             (addr_i),
        .rs2_data_i         (rs2_data_i),
        .inst_valid_i       (inst_valid_i),
        .MAC_ready          (MAC_ready),
        .MAC_data           (MAC_data),
        .misalign_o         (misalign_o),
        .mem                (mem_bus)
    );

    typedef struct {
        logic [63:0] data;
        logic        mis;
    } sb_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] word;
        logic [7:0]  wstrb;
        logic        wen;
        int          delay;
        int          gap;
    } mem_t;

    sb_t  sb[$];
    mem_t mq[$];

    int          n_vec = 0;
    int          n_err = 0;
    logic        mon_en = 1'b0;
    logic        rst_prev = 1'b0;
    logic [63:0] hold = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [63:0] ref_load(logic [63:0] w, int off, logic [2:0] f3);
        int          n;
        logic [63:0] mask;
        logic [63:0] v;
        n    = 1 << f3[1:0];
        mask = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
        v    = (w >> (8 * off)) & mask;
        if (!f3[2] && n < 8 && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    // Memory slave: answers each request with the word queued by the stimulus.
    initial begin
        mem_t e;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rsp_data  = '0;
        forever begin
            mem_bus.mem_req_ready = 1'b0;
            @(negedge clk);
            while (!mem_bus.mem_req_valid) begin
                mem_bus.mem_rsp_valid = ($urandom_range(0, 3) == 0) && !rst;
                mem_bus.mem_rsp_data  = {$urandom, $urandom};
                @(negedge clk);
            end
            mem_bus.mem_rsp_valid = 1'b0;
            if (mq.size() == 0) begin
                check("unexpected_req", {63'd0, mem_bus.mem_req_valid}, 64'd0);
            end else begin
                e = mq.pop_front();
                check("req_addr", mem_bus.mem_req_addr, e.addr);
                check("req_wen", {63'd0, mem_bus.mem_req_wen}, {63'd0, e.wen});
                if (e.wen) begin
                    check("req_wdata", mem_bus.mem_req_wdata, e.wdata);
                    check("req_wstrb", {56'd0, mem_bus.mem_req_wstrb}, {56'd0, e.wstrb});
                end
                repeat (e.delay) begin
                    @(negedge clk);
                    check("req_valid_held", {63'd0, mem_bus.mem_req_valid}, 64'd1);
                    check("req_addr_held", mem_bus.mem_req_addr, e.addr);
                    check("req_wen_held", {63'd0, mem_bus.mem_req_wen}, {63'd0, e.wen});
                    if (e.wen) begin
                        check("req_wdata_held", mem_bus.mem_req_wdata, e.wdata);
                        check("req_wstrb_held", {56'd0, mem_bus.mem_req_wstrb}, {56'd0, e.wstrb});
                    end
                end
                mem_bus.mem_req_ready = 1'b1;
                @(negedge clk);
                mem_bus.mem_req_ready = 1'b0;
                repeat (e.gap - 1) @(negedge clk);
                mem_bus.mem_rsp_valid = 1'b1;
                mem_bus.mem_rsp_data  = e.word;
                @(negedge clk);
                mem_bus.mem_rsp_valid = 1'b0;
                mem_bus.mem_rsp_data  = {$urandom, $urandom};
            end
        end
    end

    // Monitor: a completion is a cycle where an access is presented and MAC_ready is high.
    always @(negedge clk) begin
        sb_t e;
        if (mon_en) begin
            if (rst_prev) hold = '0;
            if (inst_valid_i && (load_ena_i || store_ena_i) && MAC_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", {63'd0, MAC_ready}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("mac_data", MAC_data, e.data);
                    check("misalign", {63'd0, misalign_o}, {63'd0, e.mis});
                    hold = e.data;
                end
            end else begin
                check("misalign_idle", {63'd0, misalign_o}, 64'd0);
                check("mac_data_hold", MAC_data, hold);
            end
        end
        rst_prev = rst;
    end

    task automatic push_mem(logic [63:0] addr, logic wen, logic [63:0] wdata, logic [7:0] wstrb,
                            logic [63:0] word, int delay, int gap);
        mem_t m;
        m.addr  = {addr[63:3], 3'b000};
        m.wen   = wen;
        m.wdata = wdata;
        m.wstrb = wstrb;
        m.word  = word;
        m.delay = delay;
        m.gap   = gap;
        mq.push_back(m);
    endtask

    task automatic run_access(logic ld, logic st, logic [2:0] f3, logic [63:0] addr,
                              logic [63:0] rs2, logic [63:0] word, int delay, int gap,
                              logic release_rst);
        sb_t        s;
        int         off;
        int         n;
        int         cnt;
        int         exp_lat;
        logic [7:0] strb;
        off  = int'(addr[2:0]);
        n    = 1 << f3[1:0];
        strb = '0;
        for (int i = 0; i < 8; i++) if (i >= off && i < off + n) strb[i] = 1'b1;
        s.mis  = (off % n) != 0;
        s.data = (s.mis || !ld) ? 64'd0 : ref_load(word, off, f3);
        sb.push_back(s);
        if (!s.mis) push_mem(addr, !ld, rs2 << (8 * off), strb, word, delay, gap);
        exp_lat = s.mis ? 2 : 3 + delay + gap;
        @(posedge clk);
        #1;
        if (release_rst) rst = 1'b0;
        inst_valid_i       = 1'b1;
        load_ena_i         = ld;
        store_ena_i        = st;
        load_store_bytes_i = f3;
        addr_i             = addr;
        rs2_data_i         = rs2;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!MAC_ready && cnt < 100);
        if (!MAC_ready) begin
            $display("FAIL access_timeout: got no MAC_ready after %0d cycles, expected %0d", cnt, exp_lat);
            n_err++;
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $fatal(1, "access timeout");
        end
        check("latency", 64'(cnt), 64'(exp_lat));
    endtask

    task automatic idle(int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 1) == 1) begin
                inst_valid_i = 1'b0;
                load_ena_i   = 1'($urandom);
                store_ena_i  = 1'($urandom);
            end else begin
                inst_valid_i = 1'b1;
                load_ena_i   = 1'b0;
                store_ena_i  = 1'b0;
            end
            addr_i = {$urandom, $urandom};
            @(negedge clk);
            check("idle_ready", {63'd0, MAC_ready}, 64'd1);
            check("idle_req_valid", {63'd0, mem_bus.mem_req_valid}, 64'd0);
        end
    endtask

    initial begin
        rst                = 1'b1;
        inst_valid_i       = 1'b0;
        load_ena_i         = 1'b0;
        store_ena_i        = 1'b0;
        load_store_bytes_i = '0;
        addr_i             = '0;
        rs2_data_i         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {63'd0, MAC_ready}, 64'd1);
        check("rst_mac_data", MAC_data, 64'd0);
        check("rst_misalign", {63'd0, misalign_o}, 64'd0);
        check("rst_req_valid", {63'd0, mem_bus.mem_req_valid}, 64'd0);
        check("rst_req_addr", mem_bus.mem_req_addr, 64'd0);
        check("rst_req_wdata", mem_bus.mem_req_wdata, 64'd0);
        check("rst_req_wstrb", {56'd0, mem_bus.mem_req_wstrb}, 64'd0);
        mon_en = 1'b1;

        // LB launched in the first cycle out of reset, sign-extended byte 0x80
        run_access(1'b1, 1'b0, 3'b000, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 1, 1'b1);
        // SH into the top halfword
        run_access(1'b0, 1'b1, 3'b001, 64'h8000_0006, 64'h1234, {$urandom, $urandom}, 0, 1, 1'b0);
        idle(1);
        // misaligned LW
        run_access(1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'd0, 64'd0, 0, 1, 1'b0);
        idle(1);
        // LD with ready withheld for five cycles
        run_access(1'b1, 1'b0, 3'b011, 64'h8000_0008, 64'd0, 64'hDEAD_BEEF_0123_4567, 5, 1, 1'b0);
        idle(2);

        // Reset in WAIT_RSP abandons the load; the late response must be ignored.
        push_mem(64'h8000_0010, 1'b0, 64'd0, 8'hFF, 64'h5555_AAAA_5555_AAAA, 0, 3);
        @(posedge clk);
        #1;
        inst_valid_i       = 1'b1;
        load_ena_i         = 1'b1;
        store_ena_i        = 1'b0;
        load_store_bytes_i = 3'b011;
        addr_i             = 64'h8000_0010;
        repeat (3) @(negedge clk);
        check("abort_in_wait", {63'd0, MAC_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        inst_valid_i = 1'b0;
        load_ena_i   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_mac_data", MAC_data, 64'd0);
        check("abort_req_valid", {63'd0, mem_bus.mem_req_valid}, 64'd0);
        idle(5);

        // LWU immediately followed by LBU
        run_access(1'b1, 1'b0, 3'b110, 64'h8000_0004, 64'd0, 64'hF000_0000_0000_0000, 0, 1, 1'b0);
        run_access(1'b1, 1'b0, 3'b100, 64'h8000_0001, 64'd0, 64'h0000_0000_0000_AB00, 0, 1, 1'b0);
        // load and store asserted together behaves as a load
        run_access(1'b1, 1'b1, 3'b001, 64'h8000_000A, 64'hFFFF, 64'h0000_0000_8001_0000, 0, 1, 1'b0);
        idle(1);

        for (int k = 0; k < 150; k++) begin
            int          sel;
            logic [2:0]  f3;
            sel = $urandom_range(0, 2);
            f3  = (sel == 1) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            run_access(sel != 1, sel != 0, f3, {$urandom, $urandom}, {$urandom, $urandom},
                       {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(1, 3), 1'b0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(5);

        check("sb_drained", 64'(sb.size()), 64'd0);
        check("mem_q_drained", 64'(mq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by time limit, expected end of stimulus");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_210184_mac.md
YSYX_210184_MAC -- requirements
Module: ysyx_210184_mac

Interface
REQ-001 No parameters; all data/address widths SHALL be `REG_BUS (64) from defines.v.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 load_ena_i  in  1  EX/MEM-boundary instruction is a load.
REQ-005 store_ena_i  in  1  EX/MEM-boundary instruction is a store.
REQ-006 load_store_bytes_i  in  3  funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-007 addr_i  in  64  effective address (ALU result).
REQ-008 rs2_data_i  in  64  store data, right-aligned.
REQ-009 inst_valid_i  in  1  instruction valid; access SHALL be ignored when low.
REQ-010 MAC_ready  out  1  access complete or no access; memory stage stall = ~MAC_ready.
REQ-011 MAC_data  out  64  formatted load result; valid when MAC_ready high in DONE.
REQ-012 misalign_o  out  1  one-cycle pulse in DONE for a misaligned access.
REQ-013 mem_req_valid / mem_req_ready  out/in  1/1  request handshake.
REQ-014 mem_req_addr  out  64  addr_i with bits [2:0] cleared.
REQ-015 mem_req_wen  out  1  1 = store.
REQ-016 mem_req_wdata / mem_req_wstrb  out  64/8  lane-shifted store data and byte strobes.
REQ-017 mem_rsp_valid / mem_rsp_data  in  1/64  response pulse and 64-bit aligned read word; stores also get a response.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT_RSP, DONE.
REQ-019 IDLE: MAC_ready = ~(inst_valid_i & (load_ena_i | store_ena_i)) combinationally. On a valid access, addr, bytes, wdata, wstrb, and wen SHALL be latched. Next state is REQ if aligned, else DONE with the misalign flag set.
REQ-020 Alignment rule: H requires addr[0]=0, W requires addr[1:0]=0, D requires addr[2:0]=0. A misaligned access SHALL issue no bus request.
REQ-021 REQ: mem_req_valid=1 with request fields held stable. The FSM SHALL stay in REQ until mem_req_ready, then move to WAIT_RSP. mem_req_valid SHALL NOT drop before acceptance.
REQ-022 WAIT_RSP: on mem_rsp_valid, the formatted data SHALL be latched and the FSM moves to DONE. A response arriving in any other state SHALL be ignored.
REQ-023 DONE: MAC_ready=1 and MAC_data = latched result (0 for stores or misaligned accesses). The FSM SHALL return unconditionally to IDLE; the still-present inputs SHALL NOT relaunch an access.
REQ-024 Load formatting: select the lane at byte offset addr[2:0]. B/H/W SHALL sign-extend; BU/HU/WU SHALL zero-extend; D passes through.
REQ-025 Store formatting: wdata = rs2_data_i << (8*addr[2:0]). wstrb SHALL be the 1/2/4/8-byte mask shifted left by addr[2:0].
REQ-026 Minimum load latency with ready=1 and the response one cycle after accept SHALL be 4 cycles from IDLE detection to the DONE cycle. A misaligned access SHALL take 2 cycles.
REQ-027 Outside DONE, MAC_data SHALL hold its last value. misalign_o SHALL be 0.
REQ-028 load_ena_i and store_ena_i both high SHALL be treated as a load.

Reset
REQ-029 rst SHALL force IDLE, mem_req_valid=0, MAC_data=0, misalign_o=0, and clear all latched request fields.
REQ-030 rst asserted in REQ or WAIT_RSP SHALL abandon the transaction. A late mem_rsp_valid SHALL be ignored in IDLE.
REQ-031 The first cycle after reset deassertion SHALL accept a new access.

Structure
REQ-032 State encodings and funct3 load/store size codes SHALL live in shared defines.v.
REQ-033 Load lane select and extension SHALL be one combinational sub-module, ysyx_210184_load_ext, instantiated once.
REQ-034 State and latched-request registers SHALL be plain synchronous flops. No latches and no combinational path from mem_rsp_* to MAC_ready.

Verification
REQ-035 LB, addr=0x80000003, rsp word 0x0000_0000_8000_0000, ready=1 -> MAC_data=0xFFFF_FFFF_FFFF_FF80 in cycle 4; MAC_ready low for 3 cycles.
REQ-036 SH, addr=0x80000006, rs2=0x1234 -> wdata=0x1234_0000_0000_0000, wstrb=0xC0, req_addr=0x80000000, wen=1.
REQ-037 LW, addr=0x80000002 -> no mem_req_valid; misalign_o pulses; MAC_ready low 1 cycle.
REQ-038 LD with mem_req_ready held low 5 cycles -> mem_req_valid and fields stable throughout; DONE exactly once after the response.
REQ-039 rst asserted in WAIT_RSP, then rsp arrives -> IDLE, MAC_data=0, response ignored.
REQ-040 LWU, addr=0x80000004, rsp word 0xF000_0000_0000_0000 followed immediately by a second valid LBU -> first MAC_data=0x0000_0000_F000_0000; second access launches from the IDLE cycle after DONE.
